// File: rtl/bi_mem_req_adapter.sv
// bi_mem_req_adapter: valid/ready request stream to BiMem port adapter with in-order read response FIFO
module bi_mem_req_adapter #(
  parameter int WIDTH     = 16,
  parameter int HEIGHT    = 16,
  parameter int RSP_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_isWrite_i,
  input  logic [$clog2(HEIGHT)-1:0] req_addr_i,
  input  logic [WIDTH-1:0]          req_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WIDTH-1:0]          rsp_data_o,
  output logic                      mem_enable_o,
  output logic                      mem_isWrite_o,
  output logic [$clog2(HEIGHT)-1:0] mem_addr_o,
  output logic [WIDTH-1:0]          mem_writeData_o,
  input  logic [WIDTH-1:0]          mem_readData_i,
  input  logic                      mem_hold_i
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1) + 1;
  logic [WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_inflight;
  logic             w_pop;
  logic             w_push;
  logic             w_credit_ok;
  logic             w_accept;
  logic [CW-1:0]    w_occ;
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign rsp_valid_o     = r_count != '0;
  assign rsp_data_o      = r_mem[r_rptr];
  assign mem_enable_o    = req_valid_i & w_credit_ok;
  assign req_ready_o     = w_credit_ok & ~mem_hold_i;
  assign mem_isWrite_o   = req_isWrite_i;
  assign mem_addr_o      = req_addr_i;
  assign mem_writeData_o = req_data_i;
  // reads need a free FIFO slot counting queued, in-flight and this cycle's pop
  always_comb begin
    w_pop       = rsp_valid_o & rsp_ready_i;
    w_push      = r_inflight;
    w_occ       = r_count + CW'(r_inflight) - CW'(w_pop);
    w_credit_ok = req_isWrite_i | (w_occ < CW'(RSP_DEPTH));
    w_accept    = req_valid_i & w_credit_ok & ~mem_hold_i;
  end
  // occupancy, pointers and the one-cycle read-return tracker
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept & ~req_isWrite_i;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop) r_rptr <= f_inc(r_rptr);
    end
  end
  // capture returning read data; storage is left unreset
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wptr] <= mem_readData_i;
      assert (r_count != CW'(RSP_DEPTH) || w_pop) else $error("response FIFO overflow");
    end
  end
endmodule

// File: tb/tb_bi_mem_req_adapter.sv
// tb_bi_mem_req_adapter: model-checked directed bench for bi_mem_req_adapter with a BiMem model
module tb_bi_mem_req_adapter;
  localparam int D = 2;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_isWrite_i = 1'b0;
  logic [3:0]  req_addr_i = '0;
  logic [15:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_data_o;
  logic        mem_enable_o;
  logic        mem_isWrite_o;
  logic [3:0]  mem_addr_o;
  logic [15:0] mem_writeData_o;
  logic [15:0] mem_readData_i;
  logic        mem_hold_i = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [15:0] d; int vis;} ent_t;
  ent_t q[$];
  logic [15:0] rlog[$];
  logic [15:0] mm [16];
  int n = 0;
  bit p_rd_valid = 0;
  logic [15:0] p_rd_data = '0;

  bi_mem_req_adapter #(.WIDTH(16), .HEIGHT(16), .RSP_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_isWrite_i(req_isWrite_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .mem_enable_o(mem_enable_o), .mem_isWrite_o(mem_isWrite_o), .mem_addr_o(mem_addr_o),
    .mem_writeData_o(mem_writeData_o), .mem_readData_i(mem_readData_i), .mem_hold_i(mem_hold_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", nm, act, exp, n);
    end
  endtask

  // BiMem model: read data appears only in the cycle after acceptance
  always @(posedge clk) mem_readData_i <= p_rd_valid ? p_rd_data : 16'hDEAD;

  // reference model: outstanding reads in order, each visible two cycles after acceptance
  always @(negedge clk) begin
    bit vis0, pop, cr;
    int occ;
    vis0 = q.size() > 0 && q[0].vis <= n;
    chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, vis0});
    if (vis0) chk("rsp_data", {16'b0, rsp_data_o}, {16'b0, q[0].d});
    pop = vis0 && rsp_ready_i;
    occ = q.size() - int'(pop);
    cr = req_isWrite_i || occ < D;
    chk("req_ready", {31'b0, req_ready_o}, {31'b0, cr && !mem_hold_i});
    chk("mem_enable", {31'b0, mem_enable_o}, {31'b0, req_valid_i && cr});
    chk("mem_isWrite", {31'b0, mem_isWrite_o}, {31'b0, req_isWrite_i});
    chk("mem_addr", {28'b0, mem_addr_o}, {28'b0, req_addr_i});
    chk("mem_wdata", {16'b0, mem_writeData_o}, {16'b0, req_data_i});
    p_rd_valid = 0;
    if (rst_i) q.delete();
    else begin
      if (pop) begin
        rlog.push_back(rsp_data_o);
        void'(q.pop_front());
      end
      if (req_valid_i && cr && !mem_hold_i) begin
        if (req_isWrite_i) mm[req_addr_i] = req_data_i;
        else begin
          q.push_back('{mm[req_addr_i], n + 2});
          p_rd_valid = 1;
          p_rd_data = mm[req_addr_i];
        end
      end
    end
    n++;
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic req(input bit w, input logic [3:0] a, input logic [15:0] d, input int maxc,
                     output bit ok, output int waits);
    req_valid_i = 1'b1; req_isWrite_i = w; req_addr_i = a; req_data_i = d;
    ok = 0; waits = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (req_ready_o === 1'b1) begin
        ok = 1;
        break;
      end
      waits++;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic rq(input bit w, input logic [3:0] a, input logic [15:0] d);
    bit ok;
    int wt;
    req(w, a, d, 50, ok, wt);
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int wt, base;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    idle(2);
    rst_i = 1'b0;
    chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    // single write then read
    rsp_ready_i = 1'b1;
    rq(1, 4'd3, 16'hBEEF);
    req(0, 4'd3, 16'h0, 50, ok, wt);
    @(negedge clk);
    chk("t1_lat_early", {31'b0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    chk("t1_lat_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("t1_data", {16'b0, rsp_data_o}, 32'hBEEF);
    idle(3);
    // back-to-back reads
    for (int i = 0; i < 8; i++) rq(1, 4'(i), 16'h10 + 16'(i));
    idle(2);
    base = rlog.size();
    for (int i = 0; i < 8; i++) begin
      req(0, 4'(i), 16'h0, 1, ok, wt);
      chk("t2_accept", {31'b0, ok}, 32'd1);
    end
    idle(4);
    for (int i = 0; i < 8; i++) chk("t2_order", {16'b0, rlog[base + i]}, 32'h10 + 32'(i));
    // backpressure
    rsp_ready_i = 1'b0;
    base = rlog.size();
    req(0, 4'd0, 16'h0, 1, ok, wt); chk("t3_acc0", {31'b0, ok}, 32'd1);
    req(0, 4'd1, 16'h0, 1, ok, wt); chk("t3_acc1", {31'b0, ok}, 32'd1);
    req(0, 4'd2, 16'h0, 3, ok, wt); chk("t3_blocked", {31'b0, ok}, 32'd0);
    req(1, 4'd9, 16'h5A5A, 1, ok, wt); chk("t3_write", {31'b0, ok}, 32'd1);
    rsp_ready_i = 1'b1;
    rq(0, 4'd2, 16'h0);
    rq(0, 4'd3, 16'h0);
    idle(5);
    chk("t3_count", rlog.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", {16'b0, rlog[base + i]}, 32'h10 + 32'(i));
    // hold
    rq(1, 4'd5, 16'h1234);
    idle(1);
    mem_hold_i = 1'b1;
    req_valid_i = 1'b1; req_isWrite_i = 1'b0; req_addr_i = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_ready_low", {31'b0, req_ready_o}, 32'd0);
      chk("t4_enable", {31'b0, mem_enable_o}, 32'd1);
      chk("t4_addr", {28'b0, mem_addr_o}, 32'd5);
      @(posedge clk);
      #1;
    end
    mem_hold_i = 1'b0;
    req(0, 4'd5, 16'h0, 1, ok, wt);
    chk("t4_accept", {31'b0, ok}, 32'd1);
    @(negedge clk);
    chk("t4_lat_early", {31'b0, rsp_valid_o}, 32'd0);
    @(negedge clk);
    chk("t4_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("t4_data", {16'b0, rsp_data_o}, 32'h1234);
    idle(3);
    // pop-credit edge
    rsp_ready_i = 1'b0;
    base = rlog.size();
    rq(0, 4'd0, 16'h0);
    rq(0, 4'd1, 16'h0);
    idle(2);
    rsp_ready_i = 1'b1;
    req(0, 4'd2, 16'h0, 1, ok, wt);
    chk("t5_accept", {31'b0, ok}, 32'd1);
    idle(5);
    for (int i = 0; i < 3; i++) chk("t5_order", {16'b0, rlog[base + i]}, 32'h10 + 32'(i));
    // reset mid-operation
    rsp_ready_i = 1'b0;
    rq(0, 4'd7, 16'h0);
    idle(2);
    rq(0, 4'd6, 16'h0);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    idle(3);
    rsp_ready_i = 1'b1;
    base = rlog.size();
    rq(0, 4'd4, 16'h0);
    idle(4);
    chk("t6_count", rlog.size() - base, 32'd1);
    if (rlog.size() > base) chk("t6_data", {16'b0, rlog[base]}, 32'h14);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
